// File: rtl/my_reg_wr_arbiter.sv
// Round-robin arbiter granting one requester per cycle the enable/clear/data strobes of a shared register.
// Optional grant locking is compiled in with MY_REG_ARB_LOCK_EN.
module my_reg_wr_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      en_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          clr_i,
  input  logic [N_REQ*DATA_W-1:0]   wdata_i,
`ifdef MY_REG_ARB_LOCK_EN
  input  logic [N_REQ-1:0]          lock_i,
`endif
  output logic [N_REQ-1:0]          gnt_o,
  output logic [$clog2(N_REQ)-1:0]  gnt_id_o,
  output logic                      busy_o,
  output logic                      reg_e_o,
  output logic                      reg_r_o,
  output logic [DATA_W-1:0]         reg_n_o
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned CW  = IDW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1
`ifdef MY_REG_ARB_LOCK_EN
    ,
    HOLD  = 2'd2
`endif
  } state_t;

  state_t             state_q;
  logic [IDW-1:0]     ptr_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [IDW-1:0]     gnt_id_q;
  logic               reg_e_q;
  logic               reg_r_q;
  logic [DATA_W-1:0]  reg_n_q;

  logic               win_vld;
  logic [IDW-1:0]     win_id;
  logic [CW-1:0]      cand;
  logic               hold_keep;
  logic               sel_vld;
  logic [IDW-1:0]     sel_id;
  logic               sel_clr;
  logic [DATA_W-1:0]  sel_data;
  logic [N_REQ-1:0]   gnt_d;

`ifdef MY_REG_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
  logic [CNT_W-1:0] lock_cnt_q;
`endif

  // Search starts at ptr and wraps at N_REQ, so indexes >= N_REQ are never visited
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + CW'(i);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (!win_vld && req_i[cand[IDW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
`ifdef MY_REG_ARB_LOCK_EN
    hold_keep = (state_q == HOLD) && req_i[gnt_id_q] && lock_i[gnt_id_q] &&
                (lock_cnt_q < CNT_W'(LOCK_MAX));
`else
    hold_keep = 1'b0;
`endif
    sel_vld  = hold_keep | win_vld;
    sel_id   = hold_keep ? gnt_id_q : win_id;
    sel_clr  = clr_i[sel_id];
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (sel_id == IDW'(i)) sel_data = wdata_i[i*DATA_W +: DATA_W];
    end
    gnt_d         = '0;
    gnt_d[sel_id] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      reg_e_q  <= 1'b0;
      reg_r_q  <= 1'b0;
      reg_n_q  <= '0;
`ifdef MY_REG_ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else if (!en_i || !sel_vld) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      reg_e_q  <= 1'b0;
      reg_r_q  <= 1'b0;
      reg_n_q  <= '0;
`ifdef MY_REG_ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      gnt_q    <= gnt_d;
      gnt_id_q <= sel_id;
      reg_r_q  <= sel_clr;
      reg_e_q  <= !sel_clr;
      reg_n_q  <= sel_clr ? '0 : sel_data;
      // The pointer already sits past the locked requester, so it stays frozen during HOLD
      if (!hold_keep) ptr_q <= (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + 1'b1;
`ifdef MY_REG_ARB_LOCK_EN
      if (hold_keep) begin
        state_q    <= HOLD;
        lock_cnt_q <= lock_cnt_q + 1'b1;
      end else if (lock_i[win_id]) begin
        state_q    <= HOLD;
        lock_cnt_q <= CNT_W'(1);
      end else begin
        state_q    <= GRANT;
        lock_cnt_q <= '0;
      end
`else
      state_q <= GRANT;
`endif
    end
  end

  assign gnt_o    = gnt_q;
  assign gnt_id_o = gnt_id_q;
  assign busy_o   = (state_q != IDLE);
  assign reg_e_o  = reg_e_q;
  assign reg_r_o  = reg_r_q;
  assign reg_n_o  = reg_n_q;

endmodule

// File: tb/tb_my_reg_wr_arbiter.sv
// Scoreboard bench for my_reg_wr_arbiter: directed grants queued as expected, popped by a monitor.
module tb_my_reg_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n_i, en_i;
  logic [3:0]  req_i, clr_i;
  logic [31:0] wdata_i;
  logic [3:0]  gnt_o;
  logic [1:0]  gnt_id_o;
  logic        busy_o, reg_e_o, reg_r_o;
  logic [7:0]  reg_n_o;
  logic [7:0]  data_q;
`ifdef MY_REG_ARB_LOCK_EN
  logic [3:0]  lock_i = 4'b0000;
`endif

  always #5 clk = ~clk;

  my_reg_wr_arbiter #(.N_REQ(4), .DATA_W(8), .LOCK_MAX(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .en_i(en_i), .req_i(req_i), .clr_i(clr_i),
    .wdata_i(wdata_i),
`ifdef MY_REG_ARB_LOCK_EN
    .lock_i(lock_i),
`endif
    .gnt_o(gnt_o), .gnt_id_o(gnt_id_o), .busy_o(busy_o),
    .reg_e_o(reg_e_o), .reg_r_o(reg_r_o), .reg_n_o(reg_n_o)
  );

  // The shared register the arbiter feeds
  always @(posedge clk) begin
    if (!rst_n_i)     data_q <= 8'h00;
    else if (reg_r_o) data_q <= 8'h00;
    else if (reg_e_o) data_q <= reg_n_o;
  end

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       e;
    logic       r;
    logic [7:0] n;
  } exp_t;

  exp_t q[$];
  exp_t act, exp_v;
  int   total = 0;
  int   bad   = 0;

  always @(negedge clk) begin
    if (gnt_o != 4'b0000) begin
      act = {gnt_o, gnt_id_o, busy_o, reg_e_o, reg_r_o, reg_n_o};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_grant actual=%h required=none", act);
      end else begin
        exp_v = q.pop_front();
        if (act !== exp_v) begin
          bad++;
          $display("FAIL grant_seq actual=%h required=%h", act, exp_v);
        end
      end
    end
  end

  task automatic push_w(input int k, input logic [7:0] d);
    q.push_back({4'(1 << k), 2'(k), 1'b1, 1'b1, 1'b0, d});
  endtask

  task automatic push_c(input int k);
    q.push_back({4'(1 << k), 2'(k), 1'b1, 1'b0, 1'b1, 8'h00});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] r);
    total++;
    if (a !== r) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, a, r);
    end
  endtask

  initial begin
    rst_n_i = 1'b0; en_i = 1'b1; req_i = 4'hF; clr_i = 4'h0;
    wdata_i = 32'h44_33_22_11;

    // Reset with all requesters active, then round-robin 0,1,2,3,0
    cyc(3);
    @(negedge clk);
    chk("reset_outputs", 32'({gnt_o, gnt_id_o, busy_o, reg_e_o, reg_r_o, reg_n_o}), 32'h0);
    cyc(1);
    push_w(0, 8'h11); push_w(1, 8'h22); push_w(2, 8'h33); push_w(3, 8'h44); push_w(0, 8'h11);
    rst_n_i = 1'b1;
    cyc(5);
    req_i = 4'h0;
    cyc(2);
    @(negedge clk);
    chk("idle_outputs", 32'({gnt_o, busy_o, reg_e_o, reg_r_o}), 32'h0);

    // Single write request, register picks up the data one edge after the grant
    cyc(1);
    wdata_i = 32'h00_A5_00_00; req_i = 4'b0100;
    push_w(2, 8'hA5);
    cyc(1);
    req_i = 4'b0000;
    cyc(1);
    @(negedge clk);
    chk("reg_written", 32'(data_q), 32'h0000_00A5);

    // Clear request
    cyc(1);
    wdata_i = 32'h00_00_77_00; clr_i = 4'b0010; req_i = 4'b0010;
    push_c(1);
    cyc(1);
    req_i = 4'b0000; clr_i = 4'b0000;
    cyc(1);
    @(negedge clk);
    chk("reg_cleared", 32'(data_q), 32'h0);

    // Enable dropped after a grant to 0; requester 3 resumes first (ptr=2 at entry)
    cyc(1);
    wdata_i = 32'h13_00_00_10; req_i = 4'b1001;
    push_w(3, 8'h13); push_w(0, 8'h10);
    cyc(2);
    en_i = 1'b0;
    cyc(1);
    @(negedge clk);
    chk("en_off_gnt", 32'({gnt_o, busy_o, reg_e_o, reg_r_o}), 32'h0);
    cyc(2);
    @(negedge clk);
    chk("en_off_hold", 32'({gnt_o, busy_o}), 32'h0);
    cyc(1);
    push_w(3, 8'h13); push_w(0, 8'h10);
    en_i = 1'b1;
    cyc(2);
    req_i = 4'b0000;
    cyc(2);

    // Reset in the middle of a grant to 2 (ptr=1 at entry); ptr must return to 0
    wdata_i = 32'h13_A5_00_10; req_i = 4'b0100;
    push_w(2, 8'hA5);
    cyc(1);
    rst_n_i = 1'b0;
    cyc(1);
    @(negedge clk);
    chk("mid_reset", 32'({gnt_o, gnt_id_o, busy_o, reg_e_o, reg_r_o, reg_n_o}), 32'h0);
    cyc(1);
    rst_n_i = 1'b1; req_i = 4'b1001;
    push_w(0, 8'h10);
    cyc(1);
    req_i = 4'b0000;
    cyc(2);

`ifdef MY_REG_ARB_LOCK_EN
    // Lock by requester 0 against requester 1: 8 locked grants, one to 1, then 0 relocks
    rst_n_i = 1'b0;
    cyc(2);
    rst_n_i = 1'b1; wdata_i = 32'h00_00_B1_B0; req_i = 4'b0011; lock_i = 4'b0001;
    for (int i = 0; i < 8; i++) push_w(0, 8'hB0);
    push_w(1, 8'hB1);
    for (int i = 0; i < 3; i++) push_w(0, 8'hB0);
    cyc(12);
    req_i = 4'b0000; lock_i = 4'b0000;
    cyc(2);
`endif

    cyc(3);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
